smm_sched: RTL and testbench
============================

// Module: smm_sched
// PURPOSE
//   Two-requester scheduler for one 2x2 Strassen multiplier (BUSWIDTH operand/result buses).
//   Round-robin arbitration picks one request at a time and drives the multiplier's load/sel/A/B.
//   Operands are held stable until a fixed-latency counter expires, then the result is captured and
//   returned on a valid/ready response channel tagged with the requester id.
//   Sits between the SNN layer sequencers (requesters) and the shared multiplier instance.
// PARAMETERS
//   DATAWIDTH  32               element width
//   BUSWIDTH   DATAWIDTH*4      packed 2x2 matrix width; element 00 in [DW-1:0], 01 next, then 10, 11 in top
//   MM_LAT     10               cycles from load pulse to a valid multiplier C_out; must be >= 10
// PORTS
//   clk        in   1         clock
//   rst        in   1         synchronous, active-high reset
//   req_valid  in   2         per-requester request valid; bit i = requester i
//   req_ready  out  2         per-requester accept; only the granted bit is ever high
//   req0_a     in   BUSWIDTH  requester 0 operand A
//   req0_b     in   BUSWIDTH  requester 0 operand B
//   req0_sel   in   1         requester 0 multiplier sel (reduced mode)
//   req1_a     in   BUSWIDTH  requester 1 operand A
//   req1_b     in   BUSWIDTH  requester 1 operand B
//   req1_sel   in   1         requester 1 multiplier sel
//   mm_load    out  1         multiplier load strobe
//   mm_sel     out  1         multiplier sel, held for whole job
//   mm_a       out  BUSWIDTH  multiplier A, held for whole job
//   mm_b       out  BUSWIDTH  multiplier B, held for whole job
//   mm_c       in   BUSWIDTH  multiplier C_out
//   rsp_valid  out  1         result valid
//   rsp_ready  in   1         result consumer ready
//   rsp_c      out  BUSWIDTH  captured result
//   rsp_id     out  1         requester that owns rsp_c
// BEHAVIOUR
//   - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Reset forces IDLE from any state, including mid-job.
//   - Reset values: req_ready=0, mm_load=0, mm_sel=0, mm_a=0, mm_b=0, rsp_valid=0, rsp_c=0, rsp_id=0.
//     Round-robin pointer resets to requester 0 having priority; wait counter resets to 0.
//   - IDLE: if any req_valid is set, grant per pointer: pointer=p and req_valid[p] -> grant p, else grant
//     the other requester. Assert req_ready[g] combinationally for that cycle only. The handshake
//     (valid&ready) registers operands and sel into mm_a/mm_b/mm_sel and records rsp_id<=g.
//     Pointer <= ~g. Next state is ISSUE.
//   - ISSUE: mm_load=1 for exactly one cycle; load counter <= MM_LAT-1; go to WAIT.
//   - WAIT: mm_load=0. Counter decrements each cycle; on counter==0, rsp_c<=mm_c, rsp_valid<=1, go to DONE.
//     mm_a/mm_b/mm_sel stay unchanged from grant until leaving DONE (the multiplier datapath is
//     free-running and samples operands continuously).
//   - DONE: hold rsp_valid/rsp_c/rsp_id until rsp_valid&rsp_ready. In that cycle, rsp_valid<=0 and
//     return to IDLE. No new grant occurs in the same cycle as the response handshake.
//     The earliest next req_ready is the following cycle.
//   - Back-pressure: rsp_ready low indefinitely stalls in DONE; req_ready stays 0.
//   - Simultaneous valid on both requesters: pointer decides; with both continuously valid, grants
//     alternate 0,1,0,1.
//   - A requester dropping req_valid before grant is legal; no grant is issued to it.
//   - Throughput: one job per MM_LAT+3 cycles minimum (grant, issue, MM_LAT wait, response).
// CONFIGURATION
//   SMM_SCHED_PERF_EN defined: adds output ports jobs_done[31:0] and stall_cycles[31:0].
//     jobs_done increments on each response handshake. stall_cycles increments each DONE cycle with
//     rsp_ready=0. Both reset to 0 and wrap at 2^32.
//   Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//   - Reset: assert rst 2 cycles mid-WAIT -> all outputs 0 next cycle; FSM in IDLE; no rsp_valid.
//   - Single job, req0: A=[[1,2],[3,4]], B=[[5,6],[7,8]], sel=0 -> rsp_c elements 00..11 = 19,22,43,50,
//     rsp_id=0, rsp_valid exactly MM_LAT+2 cycles after the req_ready handshake.
//   - Contention: both req_valid high from reset -> grants 0,1,0,1. req1 (A=identity, B=[[5,6],[7,8]])
//     -> rsp_c=5,6,7,8 with rsp_id=1.
//   - Back-pressure: rsp_ready low 20 cycles in DONE -> rsp_c stable, req_ready stays 0. Then raise
//     rsp_ready -> one handshake, IDLE next cycle.
//   - Operand hold: change req0_a after its grant -> mm_a unchanged until DONE exits; result matches
//     the granted operands.
//   - With SMM_SCHED_PERF_EN: 3 jobs with 4 stalled cycles total -> jobs_done=3, stall_cycles=4.

Source files
------------

// File: rtl/smm_sched_if.sv
// Handshake and multiplier bus between the layer sequencers, the scheduler and
// the shared 2x2 Strassen multiplier.
// master: requester/multiplier/consumer side. slave: the scheduler.
interface smm_sched_if #(
    parameter int BUSWIDTH = 128
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [BUSWIDTH-1:0] req0_a;
    logic [BUSWIDTH-1:0] req0_b;
    logic                req0_sel;
    logic [BUSWIDTH-1:0] req1_a;
    logic [BUSWIDTH-1:0] req1_b;
    logic                req1_sel;
    logic                mm_load;
    logic                mm_sel;
    logic [BUSWIDTH-1:0] mm_a;
    logic [BUSWIDTH-1:0] mm_b;
    logic [BUSWIDTH-1:0] mm_c;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [BUSWIDTH-1:0] rsp_c;
    logic                rsp_id;

    modport master (
        output req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel, mm_c, rsp_ready,
        input  req_ready, mm_load, mm_sel, mm_a, mm_b, rsp_valid, rsp_c, rsp_id
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel, mm_c, rsp_ready,
        output req_ready, mm_load, mm_sel, mm_a, mm_b, rsp_valid, rsp_c, rsp_id
    );
endinterface

// File: rtl/smm_sched.sv
// Two-requester round-robin scheduler for one shared 2x2 Strassen multiplier.
// A granted job's operands are parked on mm_a/mm_b/mm_sel, a one-cycle load
// strobe is issued, a fixed MM_LAT countdown waits for C_out, and the captured
// result goes back on a valid/ready response tagged with the requester id.
// Optional: define SMM_SCHED_PERF_EN to add jobs_done / stall_cycles counters.
module smm_sched #(
    parameter int DATAWIDTH = 32,
    parameter int BUSWIDTH  = DATAWIDTH * 4,
    parameter int MM_LAT    = 10
) (
    input  logic       clk,
    input  logic       rst,
    smm_sched_if.slave bus
`ifdef SMM_SCHED_PERF_EN
    ,
    output logic [31:0] jobs_done,
    output logic [31:0] stall_cycles
`endif
);

    localparam int CW = $clog2(MM_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic                ptr;
    logic [CW-1:0]       cnt;
    logic                any_req;
    logic                grant;
    logic [BUSWIDTH-1:0] gnt_a;
    logic [BUSWIDTH-1:0] gnt_b;
    logic                gnt_sel;

    assign any_req = |bus.req_valid;
    // Pointer holder wins if it is asking, otherwise the other requester.
    assign grant   = bus.req_valid[ptr] ? ptr : ~ptr;
    assign gnt_a   = grant ? bus.req1_a   : bus.req0_a;
    assign gnt_b   = grant ? bus.req1_b   : bus.req0_b;
    assign gnt_sel = grant ? bus.req1_sel : bus.req0_sel;

    // Accept strobe: only in IDLE, only to the granted requester, never during reset.
    always_comb begin
        bus.req_ready = 2'b00;
        if (state == IDLE && any_req && !rst)
            bus.req_ready[grant] = 1'b1;
    end

    // Job sequencing: grant -> load strobe -> latency countdown -> hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            cnt           <= '0;
            bus.mm_load   <= 1'b0;
            bus.mm_sel    <= 1'b0;
            bus.mm_a      <= '0;
            bus.mm_b      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_c     <= '0;
            bus.rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.mm_a    <= gnt_a;
                        bus.mm_b    <= gnt_b;
                        bus.mm_sel  <= gnt_sel;
                        bus.rsp_id  <= grant;
                        ptr         <= ~grant;
                        bus.mm_load <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mm_load <= 1'b0;
                    cnt         <= CW'(MM_LAT - 1);
                    state       <= WAIT;
                end
                WAIT: begin
                    // Multiplier samples operands continuously, so they stay parked here.
                    if (cnt == '0) begin
                        bus.rsp_c     <= bus.mm_c;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    // No grant in the handshake cycle; IDLE can grant on the next one.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SMM_SCHED_PERF_EN
    // Completed responses and cycles lost to a stalled result consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_done    <= '0;
            stall_cycles <= '0;
        end else if (state == DONE) begin
            if (bus.rsp_ready) jobs_done    <= jobs_done + 32'd1;
            else               stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_smm_sched.sv
// Self-checking bench for smm_sched: directed scenarios plus a randomized
// phase, all observed by a transaction-level scoreboard that knows only the
// arbitration rule, the job latency and the 2x2 matrix product.
module tb_smm_sched;

    localparam int DW  = 32;
    localparam int BW  = DW * 4;
    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    smm_sched_if #(.BUSWIDTH(BW)) bus ();

`ifdef SMM_SCHED_PERF_EN
    logic [31:0] jobs_done;
    logic [31:0] stall_cycles;
`endif

    smm_sched #(.DATAWIDTH(DW), .BUSWIDTH(BW), .MM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SMM_SCHED_PERF_EN
        ,
        .jobs_done    (jobs_done),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] mk(input logic [31:0] e00, input logic [31:0] e01,
                                        input logic [31:0] e10, input logic [31:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [127:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11;
        a00 = a[31:0];  a01 = a[63:32];  a10 = a[95:64];  a11 = a[127:96];
        b00 = b[31:0];  b01 = b[63:32];  b10 = b[95:64];  b11 = b[127:96];
        return {a10*b01 + a11*b11, a10*b00 + a11*b10, a00*b01 + a01*b11, a00*b00 + a01*b10};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Multiplier stand-in: result is only meaningful MM_LAT cycles after a load.
    int age = 0;
    always @(posedge clk) begin
        if (rst)                          age <= 0;
        else if (bus.mm_load)             age <= 1;
        else if (age != 0 && age < 1000)  age <= age + 1;
    end
    assign bus.mm_c = (age >= LAT) ? mat_mul(bus.mm_a, bus.mm_b) : {4{32'hDEADBEEF}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: one job in flight at most.
    bit           busy;
    bit           mp;
    int           g_cyc;
    bit           g_id;
    bit           g_sel;
    logic [127:0] g_a, g_b;
    int           m_jobs, m_stall;

    initial begin
        logic [1:0] exp_rdy;
        logic [1:0] hs;
        bit         g;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; mp = 0; m_jobs = 0; m_stall = 0;
            end else begin
                exp_rdy = 2'b00;
                if (!busy && |bus.req_valid) begin
                    g = bus.req_valid[mp] ? mp : ~mp;
                    exp_rdy[g] = 1'b1;
                end
                chk("req_ready", bus.req_ready, exp_rdy);
                hs = bus.req_valid & bus.req_ready;
                if (!busy) begin
                    chk("idle_load", bus.mm_load, 1'b0);
                    chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
                    if (|hs) begin
                        g_id  = ~hs[0];
                        g_a   = g_id ? bus.req1_a   : bus.req0_a;
                        g_b   = g_id ? bus.req1_b   : bus.req0_b;
                        g_sel = g_id ? bus.req1_sel : bus.req0_sel;
                        g_cyc = cyc;
                        mp    = ~g_id;
                        busy  = 1;
                    end
                end else begin
                    chk("hold_a", bus.mm_a, g_a);
                    chk("hold_b", bus.mm_b, g_b);
                    chk("hold_sel", bus.mm_sel, g_sel);
                    chk("load_pulse", bus.mm_load, cyc == g_cyc + 1);
                    chk("rsp_timing", bus.rsp_valid, cyc >= g_cyc + LAT + 2);
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        chk("rsp_c", bus.rsp_c, mat_mul(g_a, g_b));
                        chk("rsp_id", bus.rsp_id, g_id);
                        m_jobs++;
                        busy = 0;
                    end else if (bus.rsp_valid) begin
                        m_stall++;
                    end
                end
            end
        end
    end

    logic [127:0] last_c;
    logic         last_id;

    task automatic set_req(input bit id, input logic [127:0] a, input logic [127:0] b, input bit sel);
        if (id) begin bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; end
        else    begin bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; end
        bus.req_valid[id] = 1'b1;
    endtask

    // One job: request, scramble operands after the grant, optionally stall the response.
    task automatic do_job(input bit id, input logic [127:0] a, input logic [127:0] b,
                          input bit sel, input int stall);
        int to;
        logic [127:0] held;
        set_req(id, a, b, sel);
        bus.rsp_ready = (stall == 0);
        to = 0;
        do begin @(negedge clk); to++; end while (!(bus.req_valid[id] && bus.req_ready[id]) && to < 64);
        chk("grant_wait", to < 64, 1'b1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        if (id) begin bus.req1_a = rnd128(); bus.req1_b = rnd128(); end
        else    begin bus.req0_a = rnd128(); bus.req0_b = rnd128(); end
        to = 0;
        do begin @(negedge clk); to++; end while (!bus.rsp_valid && to < 64);
        chk("rsp_wait", to < 64, 1'b1);
        held = bus.rsp_c;
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            chk("bp_rsp_hold", bus.rsp_c, held);
            chk("bp_rdy_low", bus.req_ready, 2'b00);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        last_c  = bus.rsp_c;
        last_id = bus.rsp_id;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic chk_rst_outputs();
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_mm_load", bus.mm_load, 1'b0);
        chk("rst_mm_sel", bus.mm_sel, 1'b0);
        chk("rst_mm_a", bus.mm_a, '0);
        chk("rst_mm_b", bus.mm_b, '0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_c", bus.rsp_c, '0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
    endtask

    initial begin
        int         to;
        logic [3:0] order;
        logic [1:0] hs;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single job from requester 0; operands are scrambled after the grant
        do_job(0, mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 0);
        chk("single_c00", last_c[31:0],   32'd19);
        chk("single_c01", last_c[63:32],  32'd22);
        chk("single_c10", last_c[95:64],  32'd43);
        chk("single_c11", last_c[127:96], 32'd50);
        chk("single_id", last_id, 1'b0);

        // Leave non-zero state behind, then reset in the middle of WAIT
        do_job(1, rnd128(), rnd128(), 1'b1, 0);
        set_req(0, rnd128(), rnd128(), 1'b1);
        to = 0;
        do begin @(negedge clk); to++; end while (!bus.req_ready[0] && to < 64);
        chk("rst_job_grant", to < 64, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_rst_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_no_rsp", bus.rsp_valid, 1'b0);
        @(posedge clk); #1;

        // Contention: both requesting continuously, grants must alternate from 0
        set_req(0, mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0);
        set_req(1, mk(1, 0, 0, 1), mk(5, 6, 7, 8), 1'b0);
        bus.rsp_ready = 1'b1;
        order = '0;
        for (int k = 0; k < 4; k++) begin
            to = 0;
            do begin @(negedge clk); to++; end while (!(|(bus.req_valid & bus.req_ready)) && to < 40);
            order[k] = bus.req_ready[1];
            to = 0;
            do begin @(negedge clk); to++; end while (!(bus.rsp_valid && bus.rsp_ready) && to < 40);
            if (bus.rsp_id) chk("cont_req1_c", bus.rsp_c, mk(5, 6, 7, 8));
        end
        chk("cont_order", order, 4'b1010);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;

        // Back-pressure: 20 stalled DONE cycles while requester 1 waits
        bus.req1_a = mk(1, 0, 0, 1); bus.req1_b = mk(5, 6, 7, 8); bus.req1_sel = 1'b0;
        bus.req_valid[1] = 1'b1;
        do_job(0, rnd128(), rnd128(), 1'b0, 20);
        @(negedge clk);
        chk("bp_idle_next", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (!(bus.rsp_valid && bus.rsp_ready) && to < 40);
        chk("bp_req1_c", bus.rsp_c, mk(5, 6, 7, 8));
        chk("bp_req1_id", bus.rsp_id, 1'b1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

`ifdef SMM_SCHED_PERF_EN
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_job(0, rnd128(), rnd128(), 1'b0, 2);
        do_job(1, rnd128(), rnd128(), 1'b1, 0);
        do_job(0, rnd128(), rnd128(), 1'b0, 2);
        chk("perf_jobs", jobs_done, 32'd3);
        chk("perf_stall", stall_cycles, 32'd4);
`endif

        // Randomized traffic: valids come and go, consumer randomly stalls
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (hs[r])                              bus.req_valid[r] = 1'b0;
                else if (!bus.req_valid[r]) begin
                    if ($urandom_range(2) == 0)         set_req(r[0], rnd128(), rnd128(), 1'($urandom_range(1)));
                end else if ($urandom_range(15) == 0)   bus.req_valid[r] = 1'b0;
            end
            bus.rsp_ready = 1'($urandom_range(1));
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", bus.rsp_valid, 1'b0);
`ifdef SMM_SCHED_PERF_EN
        chk("perf_jobs_final", jobs_done, 32'(m_jobs));
        chk("perf_stall_final", stall_cycles, 32'(m_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
